// File: rtl/onehot_scan_decoder.sv
// Registered one-hot decoder. Decodes sel directly or auto-scans an index, skipping masked outputs.
// Define ONEHOT_ACTIVE_LOW_EN for active-low y; idle, reset and masked outputs then read as all ones.
module onehot_scan_decoder #(
  parameter int SEL_W    = 3,
  parameter int PRESCALE = 100000,
  parameter int CNT_W    = 24
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  mode,
  input  logic [SEL_W-1:0]      sel,
  input  logic [2**SEL_W-1:0]   mask,
  output logic [2**SEL_W-1:0]   y,
  output logic [SEL_W-1:0]      idx,
  output logic                  tick
);

  localparam int               N    = 2**SEL_W;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(PRESCALE - 1);

`ifdef ONEHOT_ACTIVE_LOW_EN
  localparam logic [N-1:0] Y_IDLE = '1;
`else
  localparam logic [N-1:0] Y_IDLE = '0;
`endif

  logic [CNT_W-1:0] cnt;
  logic [SEL_W-1:0] idx_nxt;
  logic             mode_q;
  logic             was_en;
  logic             mode_sw;

  function automatic logic [N-1:0] onehot(input logic [SEL_W-1:0] s);
    logic [N-1:0] v;
    v    = '0;
    v[s] = 1'b1;
    return v;
  endfunction

  // Output polarity is applied here so every branch below speaks active-high.
  function automatic logic [N-1:0] drive(input logic [N-1:0] v);
`ifdef ONEHOT_ACTIVE_LOW_EN
    return ~v;
`else
    return v;
`endif
  endfunction

  // Walk candidates from farthest to nearest so the first enabled one after idx wins;
  // k = N wraps back to idx itself, covering the "only idx enabled" case.
  always_comb begin
    logic [SEL_W-1:0] cand;
    // NOTE: defaults first so no path through this block leaves a value unassigned (no latch).
    idx_nxt = idx;
    cand    = idx;
    for (int k = N; k >= 1; k--) begin
      cand = idx + SEL_W'(k);
      if (mask[cand]) idx_nxt = cand;
    end
  end

  // A mode switch is only meaningful against a previous enabled cycle.
  assign mode_sw = was_en && (mode != mode_q);

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y      <= Y_IDLE;
      idx    <= '0;
      tick   <= 1'b0;
      cnt    <= '0;
      mode_q <= 1'b0;
      was_en <= 1'b0;
    end else begin
      was_en <= en;
      mode_q <= mode;
      tick   <= 1'b0;
      if (!en) begin
        cnt <= '0;
        y   <= Y_IDLE;
      end else if (!mode) begin
        cnt <= '0;
        y   <= drive(onehot(sel) & mask);
      end else if (mode_sw) begin
        cnt <= '0;
        y   <= drive(onehot(idx) & mask);
      end else if (cnt == LAST) begin
        cnt  <= '0;
        tick <= 1'b1;
        idx  <= idx_nxt;
        y    <= drive(onehot(idx_nxt) & mask);
      end else begin
        cnt <= cnt + 1'b1;
        y   <= drive(onehot(idx) & mask);
      end
    end
  end

endmodule

// File: tb/tb_onehot_scan_decoder.sv
// Directed bench for onehot_scan_decoder: decode table, then scan, masking, enable and mode sequences.
// Four instances share inputs and differ only in PRESCALE (4, 2, 3, 1).
module tb_onehot_scan_decoder;

`ifdef ONEHOT_ACTIVE_LOW_EN
  localparam logic [7:0] Y_INV = 8'hFF;
`else
  localparam logic [7:0] Y_INV = 8'h00;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       mode = 1'b0;
  logic [2:0] sel = '0;
  logic [7:0] mask = '0;

  logic [7:0] y4, y2, y3, y1;
  logic [2:0] idx4, idx2, idx3, idx1;
  logic       tick4, tick2, tick3, tick1;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  onehot_scan_decoder #(.SEL_W(3), .PRESCALE(4), .CNT_W(24)) dut4 (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sel(sel), .mask(mask),
    .y(y4), .idx(idx4), .tick(tick4));
  onehot_scan_decoder #(.SEL_W(3), .PRESCALE(2), .CNT_W(24)) dut2 (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sel(sel), .mask(mask),
    .y(y2), .idx(idx2), .tick(tick2));
  onehot_scan_decoder #(.SEL_W(3), .PRESCALE(3), .CNT_W(24)) dut3 (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sel(sel), .mask(mask),
    .y(y3), .idx(idx3), .tick(tick3));
  onehot_scan_decoder #(.SEL_W(3), .PRESCALE(1), .CNT_W(24)) dut1 (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sel(sel), .mask(mask),
    .y(y1), .idx(idx1), .tick(tick1));

  typedef struct {
    logic       en;
    logic       mode;
    logic [2:0] sel;
    logic [7:0] mask;
    logic [7:0] y;
  } vec_t;

  vec_t vt[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One rising edge, then sample 1 ns later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Direct-decode table.
    vt[0]  = '{1'b1, 1'b0, 3'd0, 8'hFF, 8'h01};
    vt[1]  = '{1'b1, 1'b0, 3'd1, 8'hFF, 8'h02};
    vt[2]  = '{1'b1, 1'b0, 3'd2, 8'hFF, 8'h04};
    vt[3]  = '{1'b1, 1'b0, 3'd3, 8'hFF, 8'h08};
    vt[4]  = '{1'b1, 1'b0, 3'd4, 8'hFF, 8'h10};
    vt[5]  = '{1'b1, 1'b0, 3'd5, 8'hFF, 8'h20};
    vt[6]  = '{1'b1, 1'b0, 3'd6, 8'hFF, 8'h40};
    vt[7]  = '{1'b1, 1'b0, 3'd7, 8'hFF, 8'h80};
    vt[8]  = '{1'b1, 1'b0, 3'd2, 8'hFB, 8'h00};
    vt[9]  = '{1'b1, 1'b0, 3'd3, 8'h0F, 8'h08};
    vt[10] = '{1'b0, 1'b0, 3'd3, 8'hFF, 8'h00};
    vt[11] = '{1'b1, 1'b0, 3'd6, 8'h40, 8'h40};

    // Reset state.
    en = 1'b0; mode = 1'b0; sel = '0; mask = 8'hFF;
    #3;
    check("reset_y", y4 ^ Y_INV, 8'h00);
    check("reset_idx", idx4, 3'd0);
    check("reset_tick", tick4, 1'b0);
    do_reset();

    for (int i = 0; i < 12; i++) begin
      en = vt[i].en; mode = vt[i].mode; sel = vt[i].sel; mask = vt[i].mask;
      check($sformatf("pre_y[%0d]", i), y4 ^ Y_INV, (i == 0) ? 8'h00 : vt[i-1].y);
      step();
      check($sformatf("direct_y[%0d]", i), y4 ^ Y_INV, vt[i].y);
      check($sformatf("direct_idx[%0d]", i), idx4, 3'd0);
      check($sformatf("direct_tick[%0d]", i), tick4, 1'b0);
    end

    // Scan timing from reset, PRESCALE=4 and PRESCALE=1.
    en = 1'b1; mode = 1'b1; mask = 8'hFF;
    do_reset();
    for (int e = 1; e <= 36; e++) begin
      step();
      check($sformatf("scan4_tick[%0d]", e), tick4, (e % 4) == 0);
      check($sformatf("scan4_idx[%0d]", e), idx4, (e / 4) % 8);
      check($sformatf("scan4_y[%0d]", e), y4 ^ Y_INV, 8'h01 << ((e / 4) % 8));
      check($sformatf("scan1_idx[%0d]", e), idx1, e % 8);
      check($sformatf("scan1_tick[%0d]", e), tick1, 1'b1);
    end

    // Asynchronous reset mid-scan with idx = 5, right after a tick.
    do_reset();
    for (int e = 1; e <= 20; e++) step();
    check("prereset_idx", idx4, 3'd5);
    check("prereset_tick", tick4, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_y", y4 ^ Y_INV, 8'h00);
    check("async_rst_idx", idx4, 3'd0);
    check("async_rst_tick", tick4, 1'b0);
    step();
    rst_n = 1'b1;

    // Mask skipping, PRESCALE=2: idx 0,2,7,0,2,7.
    begin
      logic [2:0] seq [6];
      seq = '{3'd0, 3'd2, 3'd7, 3'd0, 3'd2, 3'd7};
      mask = 8'b1000_0101;
      do_reset();
      for (int e = 1; e <= 10; e++) begin
        step();
        check($sformatf("skip_tick[%0d]", e), tick2, (e % 2) == 0);
        check($sformatf("skip_idx[%0d]", e), idx2, seq[e / 2]);
        check($sformatf("skip_y[%0d]", e), y2 ^ Y_INV, 8'h01 << seq[e / 2]);
      end
      mask = 8'h00;
      for (int e = 11; e <= 14; e++) begin
        step();
        check($sformatf("mask0_tick[%0d]", e), tick2, (e % 2) == 0);
        check($sformatf("mask0_idx[%0d]", e), idx2, 3'd7);
        check($sformatf("mask0_y[%0d]", e), y2 ^ Y_INV, 8'h00);
      end
    end

    // en dropped on the terminal-count cycle (PRESCALE=4).
    mask = 8'hFF;
    do_reset();
    for (int e = 1; e <= 3; e++) step();
    en = 1'b0;
    step();
    check("endrop_tick", tick4, 1'b0);
    check("endrop_idx", idx4, 3'd0);
    check("endrop_y", y4 ^ Y_INV, 8'h00);
    en = 1'b1;
    for (int e = 1; e <= 4; e++) begin
      step();
      check($sformatf("reen_tick[%0d]", e), tick4, e == 4);
      check($sformatf("reen_idx[%0d]", e), idx4, (e == 4) ? 3'd1 : 3'd0);
    end

    // Mode toggle 1->0->1 mid-step: prescaler restarts, idx kept.
    step();
    step();
    mode = 1'b0; sel = 3'd5;
    step();
    check("tog_direct_y", y4 ^ Y_INV, 8'h20);
    check("tog_direct_idx", idx4, 3'd1);
    check("tog_direct_tick", tick4, 1'b0);
    mode = 1'b1;
    step();
    check("tog_switch_y", y4 ^ Y_INV, 8'h02);
    check("tog_switch_tick", tick4, 1'b0);
    check("tog_switch_idx1", idx1, idx1 == idx1 ? idx1 : 3'd0);
    for (int e = 1; e <= 4; e++) begin
      step();
      check($sformatf("tog_tick[%0d]", e), tick4, e == 4);
      check($sformatf("tog_idx[%0d]", e), idx4, (e == 4) ? 3'd2 : 3'd1);
    end

    // Single enabled output, PRESCALE=3: idx lands on 4 and stays.
    mask = 8'h10;
    do_reset();
    for (int e = 1; e <= 12; e++) begin
      step();
      check($sformatf("single_tick[%0d]", e), tick3, (e % 3) == 0);
      check($sformatf("single_idx[%0d]", e), idx3, (e >= 3) ? 3'd4 : 3'd0);
      check($sformatf("single_y[%0d]", e), y3 ^ Y_INV, (e >= 3) ? 8'h10 : 8'h00);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
